// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    localparam int LINE_WORDS = 4;
    localparam int OFFSET_W   = 2;

    // Results are 16 bits wide; callers narrow them to the field width they need.
    function automatic logic [15:0] addr_tag(input logic [15:0] a, input int index_w);
        return a >> (index_w + OFFSET_W);
    endfunction

    function automatic logic [15:0] addr_index(input logic [15:0] a, input int index_w);
        return (a >> OFFSET_W) & ((16'd1 << index_w) - 16'd1);
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [15:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid bits and tags for each cache line, with the combinational hit compare.
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int INDEX_W   = 3,
    parameter int TAG_W     = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] lookup_index,
    input  logic [TAG_W-1:0]   lookup_tag,
    output logic               hit,
    input  logic               write_en,
    input  logic [INDEX_W-1:0] write_index,
    input  logic [TAG_W-1:0]   write_tag,
    input  logic               write_valid,
    input  logic               invalidate
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags [NUM_LINES];

    // A fill write in the same cycle as invalidate wins for its own line.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= '0;
        end else begin
            if (invalidate)
                valid <= '0;
            if (write_en)
                valid[write_index] <= write_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (write_en)
            tags[write_index] <= write_tag;
    end

    assign hit = valid[lookup_index] && (tags[lookup_index] == lookup_tag);

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: same-cycle hits, 4-beat line refill on a miss.
module instr_cache
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [15:0] addr,
    output logic [15:0] rdata,
    output logic        ready,
    input  logic        invalidate,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = 16 - INDEX_W - OFFSET_W;

    state_t state, state_next;

    logic [1:0]  beat;
    logic        abort;
    logic        replay;
    logic [13:0] base_line;
    logic [15:0] data_mem [NUM_LINES*LINE_WORDS];

    logic [TAG_W-1:0]    lookup_tag;
    logic [INDEX_W-1:0]  lookup_index;
    logic [OFFSET_W-1:0] lookup_offset;
    logic [TAG_W-1:0]    base_tag;
    logic [INDEX_W-1:0]  base_index;

    logic hit;
    logic access;
    logic lookup_hit;
    logic miss_start;
    logic fill_beat;
    logic fill_done;

    assign lookup_tag    = TAG_W'(addr_tag(addr, INDEX_W));
    assign lookup_index  = INDEX_W'(addr_index(addr, INDEX_W));
    assign lookup_offset = addr_offset(addr);
    assign base_tag      = base_line[13:INDEX_W];
    assign base_index    = base_line[INDEX_W-1:0];

    assign access     = (state == ST_IDLE) && req;
    assign lookup_hit = access && hit;
    assign miss_start = access && !hit;
    assign fill_beat  = (state == ST_FILL) && mem_ack;
    assign fill_done  = fill_beat && (beat == 2'd3);

    icache_tag_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_tag_array (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_index (lookup_index),
        .lookup_tag   (lookup_tag),
        .hit          (hit),
        .write_en     (fill_done),
        .write_index  (base_index),
        .write_tag    (base_tag),
        .write_valid  (!abort && !invalidate),
        .invalidate   (invalidate)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (miss_start) state_next = ST_FILL;
            ST_FILL: if (fill_done)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        mem_req  = 1'b0;
        mem_addr = 16'd0;
        rdata    = 16'd0;
        case (state)
            ST_IDLE: begin
                ready = !req || hit;
                if (lookup_hit)
                    rdata = data_mem[{lookup_index, lookup_offset}];
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = {base_line, beat};
            end
            default: ;
        endcase
    end

    // Replay lasts exactly one IDLE cycle: the one right after fill completion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            beat   <= 2'd0;
            abort  <= 1'b0;
            replay <= 1'b0;
        end else begin
            replay <= fill_done;
            if (miss_start) begin
                beat  <= 2'd0;
                abort <= 1'b0;
            end else if (state == ST_FILL) begin
                if (mem_ack)
                    beat <= beat + 2'd1;
                if (invalidate)
                    abort <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (miss_start)
            base_line <= addr[15:2];
    end

    always_ff @(posedge clk) begin
        if (fill_beat)
            data_mem[{base_index, beat}] <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else begin
            if (lookup_hit && !replay)
                hit_count <= hit_count + 16'd1;
            if (miss_start)
                miss_count <= miss_count + 16'd1;
        end
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port (address1/data1) and the slower instruction memory. Fetch hits return a 16-bit word in the same cycle. On a miss the cache stalls fetch, refills a 4-word line from memory with a per-word request/acknowledge handshake, then serves the access. It also keeps hit/miss statistics for the testbench.

## Interface
- NUM_LINES, 8, number of lines; power of two, at least 2; INDEX_W = log2(NUM_LINES)
- LINE_WORDS, 4, words per line; fixed at 4 (OFFSET_W = 2)
- clk  in  1  clock
- reset_n  in  1  reset; synchronous, active-low
- req  in  1  fetch request from the datapath
- addr  in  16  word address of the fetch
- rdata  out  16  fetched instruction; valid when req && ready
- ready  out  1  access completes this cycle; when low, the datapath holds PC and IF/ID
- invalidate  in  1  one-cycle pulse that clears all valid bits
- mem_req  out  1  refill beat request to memory
- mem_addr  out  16  word address of the current beat
- mem_ack  in  1  one-cycle pulse; mem_rdata is valid in this cycle
- mem_rdata  in  16  refill data
- hit_count  out  16  accesses completed as hits
- miss_count  out  16  misses taken

## Operation
- Address split: tag = addr[15:INDEX_W+2], index = addr[INDEX_W+1:2], offset = addr[1:0].
- Storage: valid[NUM_LINES], tag[NUM_LINES], data[NUM_LINES][4].
- hit = valid[index] && tag[index] == tag(addr). The hit path is combinational.
- FSM has two states: IDLE and FILL.
- IDLE, with req && hit:
  - ready = 1; rdata = data[index][offset].
  - hit_count increments, except on the replay cycle (see below).
- IDLE, with req && !hit:
  - ready = 0; go to FILL.
  - Latch the line base: addr with offset forced to 00.
  - Clear beat to 0 and abort to 0; miss_count increments.
- IDLE, with !req: ready = 1 and no state change.
- FILL:
  - mem_req = 1; mem_addr = base + beat; ready = 0.
  - On each mem_ack, write mem_rdata into data[base index][beat] and increment beat.
  - The ack for beat 3 ends the fill. Write tag[index] = base tag and valid[index] = !abort, set the replay flag, and return to IDLE.
- Replay cycle: the first IDLE cycle after a fill. The lookup of the current addr is redone. A hit in this cycle is not counted in hit_count. A miss starts a new fill and is counted.
- Any address change on addr during FILL is ignored. The lookup uses the address present in the next IDLE cycle.
- invalidate:
  - In IDLE: all valid bits clear at the next edge. A lookup in the same cycle uses the pre-invalidate contents.
  - In FILL: all valid bits clear and abort is set. The bus handshake still completes all 4 beats, but the line is not marked valid.
- Counters wrap modulo 2^16.

## Timing
- Reset values:
  - state = IDLE, beat = 0, abort = 0, replay = 0.
  - All valid bits = 0; tag and data arrays are not reset.
  - mem_req = 0, mem_addr = 0, rdata = 0 when not hitting, ready = 1 (req low).
  - hit_count = 0, miss_count = 0.
- Hit latency: 0 cycles (same cycle).
- Miss penalty: 1 cycle (IDLE→FILL) plus the sum of the 4 beat latencies plus 1 replay cycle.
- mem_req stays high for the whole of FILL. mem_addr changes only in the cycle after an ack.
- mem_ack outside FILL is ignored.
- Reset during FILL: the fill is aborted immediately and mem_req drops at the next edge. The memory model must discard any outstanding beat.
- When valid[i] is written in the fill-completion cycle, that line is usable starting with the replay cycle.

## Structure
- Package icache_pkg holds:
  - state encoding (ST_IDLE, ST_FILL);
  - LINE_WORDS and OFFSET_W constants;
  - tag/index/offset extraction functions parameterised by INDEX_W.
- One sub-module, icache_tag_array: valid and tag storage, comparison, and invalidate. Data array and FSM stay in the top.

## Test plan
- Cold miss:
  - Stimulus: after reset, req with addr = 0x0005; memory acks each beat after 2 cycles and returns mem_rdata = 0xA000 + mem_addr.
  - Response: mem_addr steps 0x0004..0x0007; ready rises on the replay cycle with rdata = 0xA005; miss_count = 1, hit_count = 0.
- Hit in same line: addr = 0x0006 in the next cycle → ready = 1 in the same cycle, rdata = 0xA006, hit_count = 1, mem_req stays 0.
- Conflict eviction (NUM_LINES = 8):
  - Stimulus: fetch 0x0004, then 0x0024 (same index, different tag), then 0x0004 again.
  - Response: three misses, miss_count = 3, and the final rdata equals the memory's data for 0x0004.
- Invalidate during fill:
  - Stimulus: pulse invalidate while beat = 2 of a fill for 0x0010.
  - Response: the fill still issues 4 beats; the replay misses and refills 0x0010 again; miss_count increments twice.
- Reset mid-fill:
  - Stimulus: assert reset_n = 0 during beat 1.
  - Response: next cycle mem_req = 0, both counters = 0; a later fetch of a previously filled address misses.
- Counter wrap: preload traffic for 65536 hits → hit_count returns to 0x0000; miss_count is unaffected.
